apb_slave_mem: RTL and testbench
================================

// Module: apb_slave_mem
// PURPOSE
//  APB3 slave memory: the peripheral directly downstream of the AHB2APB bridge.
//  Consumes the bridge's psel/penable/pwrite/paddr/pwdata and returns prdata/pready/pslverr.
//  Provides DEPTH 32-bit word registers with a programmable wait-state count,
//  so the bridge's wait/extend logic is exercised. One clock domain (hclk).
// PARAMETERS
//  DEPTH        16  number of 32-bit words (power of 2, >=2)
//  ADDR_W       32  paddr width; must be >= $clog2(DEPTH)+2
//  WAIT_STATES  0   pready-low cycles inserted in access phase (0..15)
// PORTS
//  hclk     in   1       clock, rising edge
//  hreset   in   1       asynchronous, active-high reset
//  psel     in   1       slave select from bridge
//  penable  in   1       access phase indicator
//  pwrite   in   1       1=write, 0=read
//  paddr    in   ADDR_W  byte address; word index = paddr[$clog2(DEPTH)+1:2]
//  pwdata   in   32      write data
//  prdata   out  32      read data, valid while pready=1 on a read
//  pready   out  1       transfer completes on edge where psel&penable&pready
//  pslverr  out  1       error response, valid only while pready=1
// BEHAVIOUR
//  Reset (hreset=1, async): state=IDLE, cnt=0, pready=0, pslverr=0, prdata=0, all words=0.
//  All outputs are registered; no combinational path from inputs to outputs.
//  FSM states: IDLE, WAIT, READY.
//   IDLE : on edge with psel=1 & penable=0 (setup), latch addr/pwrite/pwdata;
//          WAIT_STATES==0 -> READY, else -> WAIT with cnt=WAIT_STATES-1.
//          penable=1 without a preceding setup is ignored (stay IDLE).
//   WAIT : psel=0 -> IDLE (abort, no write, no response). cnt==0 -> READY, else cnt--.
//   READY: pready=1 for exactly one cycle; -> IDLE next edge.
//  Access-phase length = WAIT_STATES+1 cycles; pready is 0 in all other cycles.
//  Read: prdata loaded with mem[idx] on entry to READY; returns to 0 on leaving READY.
//  Write: mem[idx] <= latched pwdata on the READY-exit edge (psel&penable&pready).
//  Data/addr are latched at setup; changes during the access phase are ignored.
//  Back-to-back: a setup on the cycle after READY is accepted (IDLE samples it).
//  paddr[1:0] ignored (word access only; no pstrb, APB3).
//  Reset asserted mid-transfer: the transfer is dropped, any pending write is lost,
//  and the outputs go to their reset values immediately.
// CONFIGURATION
//  Macro APB_SLV_ERR_EN:
//   defined  : word index >= DEPTH, or any paddr bit above the index field nonzero,
//              -> pslverr=1 in READY, write suppressed, prdata=0.
//   undefined: upper address bits ignored, index wraps modulo DEPTH; pslverr tied 0.
// STRUCTURE
//  apb_pkg: typedef enum logic[1:0] {IDLE,WAIT,READY} apb_slv_state_t;
//           localparam APB_DATA_W=32; localparam MAX_WAIT=15.
//  Sub-module apb_regbank: DEPTH x 32 storage with async-reset clear, one write port
//  (we, widx, wdata) and one asynchronous read port (ridx -> rdata).
//  FSM, wait counter and error decode stay in apb_slave_mem.
// TESTING
//  1 WAIT_STATES=0: write 0xA5A5_0001 @0x04, then read @0x04 -> pready high on the
//    first access cycle, prdata=0xA5A5_0001, pslverr=0.
//  2 WAIT_STATES=3: read @0x08 after write 0x1234_5678 -> pready low 3 access cycles,
//    high on the 4th; prdata=0x1234_5678 only in that cycle.
//  3 Back-to-back writes 0x11 @0x00 and 0x22 @0x3C with no idle cycle, then reads
//    -> 0x11 and 0x22; both transfers complete.
//  4 APB_SLV_ERR_EN, DEPTH=16: write 0xDEAD @0x40 -> pslverr=1 with pready;
//    read @0x00 unchanged. Without the macro: the same write lands at word 0.
//  5 WAIT_STATES=5: assert hreset during the WAIT of a write 0xFF @0x10 -> pready=0
//    at once; a later read @0x10 -> 0x0.
//  6 psel dropped during WAIT -> returns to IDLE, no pready pulse, memory unchanged.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB3 slave memory.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READY
    } apb_slv_state_t;

    localparam int APB_DATA_W = 32;
    localparam int MAX_WAIT   = 15;

endpackage

// File: rtl/apb_regbank.sv
// DEPTH x 32 word storage: one synchronous write port, one asynchronous read port.
module apb_regbank
    import apb_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [APB_DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]      ridx,
    output logic [APB_DATA_W-1:0] rdata
);

    logic [APB_DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 slave memory with a fixed number of wait states in the access phase.
// Optional APB_SLV_ERR_EN: out-of-range addresses answer with pslverr instead of wrapping.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic [APB_DATA_W-1:0] pwdata,
    output logic [APB_DATA_W-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);
`ifdef APB_SLV_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    apb_slv_state_t        state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [ADDR_W-1:0]     addr_q;
    logic                  write_q;
    logic [APB_DATA_W-1:0] wdata_q;

    logic                  setup;
    logic [ADDR_W-1:0]     addr_nxt;
    logic                  write_nxt;
    logic                  err_nxt;
    logic                  we;
    logic [APB_DATA_W-1:0] rdata;

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
        return a[IDX_W+1:2];
    endfunction

    // Any address bit above the word-index field marks the access as out of range.
    function automatic logic addr_err(input logic [ADDR_W-1:0] a);
        return ERR_EN && (|(a >> (IDX_W + 2)));
    endfunction

    assign setup     = (state == IDLE) && psel && !penable;
    assign addr_nxt  = setup ? paddr  : addr_q;
    assign write_nxt = setup ? pwrite : write_q;
    assign err_nxt   = addr_err(addr_nxt);
    assign we        = (state == READY) && psel && penable && write_q && !addr_err(addr_q);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (setup) begin
                    state_nxt = (WAIT_STATES == 0) ? READY : WAIT;
                    cnt_nxt   = CNT_INIT;
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    state_nxt = READY;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            READY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state   <= IDLE;
            cnt     <= '0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pready  <= (state_nxt == READY);
            pslverr <= (state_nxt == READY) && err_nxt;
            prdata  <= ((state_nxt == READY) && !write_nxt && !err_nxt) ? rdata : '0;
        end
    end

    // Transfer attributes are captured once at setup; the access phase cannot alter them.
    always_ff @(posedge hclk) begin
        if (setup) begin
            addr_q  <= paddr;
            write_q <= pwrite;
            wdata_q <= pwdata;
        end
    end

    apb_regbank #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_regbank (
        .clk   (hclk),
        .rst   (hreset),
        .we    (we),
        .widx  (idx_of(addr_q)),
        .wdata (wdata_q),
        .ridx  (idx_of(addr_nxt)),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three instances (0, 3 and 5 wait states) on one shared APB bus.
module tb_apb_slave_mem;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [2:0]  psel_v;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata_a  [3];
    logic        pready_a  [3];
    logic        pslverr_a [3];

    int errors = 0;
    int checks = 0;

    always #5 hclk = ~hclk;

    apb_slave_mem #(.DEPTH(16), .ADDR_W(32), .WAIT_STATES(0)) u_ws0 (
        .hclk(hclk), .hreset(hreset), .psel(psel_v[0]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata_a[0]), .pready(pready_a[0]), .pslverr(pslverr_a[0]));

    apb_slave_mem #(.DEPTH(16), .ADDR_W(32), .WAIT_STATES(3)) u_ws3 (
        .hclk(hclk), .hreset(hreset), .psel(psel_v[1]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata_a[1]), .pready(pready_a[1]), .pslverr(pslverr_a[1]));

    apb_slave_mem #(.DEPTH(16), .ADDR_W(32), .WAIT_STATES(5)) u_ws5 (
        .hclk(hclk), .hreset(hreset), .psel(psel_v[2]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata_a[2]), .pready(pready_a[2]), .pslverr(pslverr_a[2]));

    typedef struct {
        string       name;
        int          dut;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_waits;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called 1ns after a rising edge; drives setup immediately, so consecutive calls are back-to-back.
    task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int waits);
        psel_v    = '0;
        psel_v[d] = 1'b1;
        penable   = 1'b0;
        pwrite    = wr;
        paddr     = a;
        pwdata    = wd;
        @(posedge hclk); #1;
        penable = 1'b1;
        paddr   = ~a;
        pwdata  = ~wd;
        waits   = 0;
        while (!pready_a[d] && waits < 40) begin
            @(posedge hclk); #1;
            waits++;
        end
        rd = prdata_a[d];
        er = pslverr_a[d];
        if (!pready_a[d]) begin
            checks++;
            errors++;
            $display("FAIL timeout: dut%0d addr %h never raised pready", d, a);
        end
        @(posedge hclk); #1;
        psel_v  = '0;
        penable = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] rd;
        logic        er;
        int          waits;
        xfer(v.dut, v.wr, v.addr, v.wdata, rd, er, waits);
        chk({v.name, " prdata"}, rd, v.exp_rd);
        chk({v.name, " pslverr"}, {31'd0, er}, {31'd0, v.exp_err});
        chk({v.name, " wait cycles"}, waits, v.exp_waits);
        chk({v.name, " pready after"}, {31'd0, pready_a[v.dut]}, 32'd0);
        chk({v.name, " prdata after"}, prdata_a[v.dut], 32'd0);
    endtask

    function automatic vec_t mk(input string n, input int d, input logic wr, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd, input logic er,
                                input int w);
        vec_t v;
        v.name = n; v.dut = d; v.wr = wr; v.addr = a; v.wdata = wd;
        v.exp_rd = rd; v.exp_err = er; v.exp_waits = w;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        vec_t v;

        vecs[0]  = mk("w04_ws0", 0, 1'b1, 32'h04, 32'hA5A5_0001, 32'h0, 1'b0, 0);
        vecs[1]  = mk("r04_ws0", 0, 1'b0, 32'h04, 32'h0, 32'hA5A5_0001, 1'b0, 0);
        vecs[2]  = mk("w08_ws3", 1, 1'b1, 32'h08, 32'h1234_5678, 32'h0, 1'b0, 3);
        vecs[3]  = mk("r08_ws3", 1, 1'b0, 32'h08, 32'h0, 32'h1234_5678, 1'b0, 3);
        vecs[4]  = mk("b2b_w00", 0, 1'b1, 32'h00, 32'h11, 32'h0, 1'b0, 0);
        vecs[5]  = mk("b2b_w3c", 0, 1'b1, 32'h3C, 32'h22, 32'h0, 1'b0, 0);
        vecs[6]  = mk("b2b_r00", 0, 1'b0, 32'h00, 32'h0, 32'h11, 1'b0, 0);
        vecs[7]  = mk("b2b_r3c", 0, 1'b0, 32'h3C, 32'h0, 32'h22, 1'b0, 0);
`ifdef APB_SLV_ERR_EN
        vecs[8]  = mk("w40_oob", 0, 1'b1, 32'h40, 32'hDEAD, 32'h0, 1'b1, 0);
        vecs[9]  = mk("r00_post", 0, 1'b0, 32'h00, 32'h0, 32'h11, 1'b0, 0);
`else
        vecs[8]  = mk("w40_wrap", 0, 1'b1, 32'h40, 32'hDEAD, 32'h0, 1'b0, 0);
        vecs[9]  = mk("r00_post", 0, 1'b0, 32'h00, 32'h0, 32'hDEAD, 1'b0, 0);
`endif
        vecs[10] = mk("r3f_lowbits", 0, 1'b0, 32'h3F, 32'h0, 32'h22, 1'b0, 0);
`ifdef APB_SLV_ERR_EN
        vecs[11] = mk("r44_oob", 0, 1'b0, 32'h44, 32'h0, 32'h0, 1'b1, 0);
`else
        vecs[11] = mk("r44_wrap", 0, 1'b0, 32'h44, 32'h0, 32'hA5A5_0001, 1'b0, 0);
`endif
        vecs[12] = mk("w14_ws5", 2, 1'b1, 32'h14, 32'hCAFE_0005, 32'h0, 1'b0, 5);
        vecs[13] = mk("r14_ws5", 2, 1'b0, 32'h14, 32'h0, 32'hCAFE_0005, 1'b0, 5);

        hreset  = 1'b1;
        psel_v  = '0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        repeat (2) @(posedge hclk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset pready dut%0d", d), {31'd0, pready_a[d]}, 32'd0);
            chk($sformatf("reset pslverr dut%0d", d), {31'd0, pslverr_a[d]}, 32'd0);
            chk($sformatf("reset prdata dut%0d", d), prdata_a[d], 32'd0);
        end
        #1 hreset = 1'b0;
        @(posedge hclk); #1;

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i]);
        end

        // Access phase with no preceding setup must be ignored.
        psel_v[0] = 1'b1;
        penable   = 1'b1;
        pwrite    = 1'b1;
        paddr     = 32'h00;
        pwdata    = 32'h77;
        pulses    = 0;
        repeat (3) begin
            @(posedge hclk); #1;
            if (pready_a[0]) pulses++;
        end
        chk("no-setup pready pulses", pulses, 0);
        psel_v  = '0;
        penable = 1'b0;
        @(posedge hclk); #1;
`ifdef APB_SLV_ERR_EN
        run_vec(mk("no-setup r00", 0, 1'b0, 32'h00, 32'h0, 32'h11, 1'b0, 0));
`else
        run_vec(mk("no-setup r00", 0, 1'b0, 32'h00, 32'h0, 32'hDEAD, 1'b0, 0));
`endif

        // psel dropped during WAIT aborts the write silently.
        psel_v[1] = 1'b1;
        penable   = 1'b0;
        pwrite    = 1'b1;
        paddr     = 32'h08;
        pwdata    = 32'hBEEF;
        @(posedge hclk); #1;
        penable = 1'b1;
        @(posedge hclk); #1;
        psel_v  = '0;
        penable = 1'b0;
        pulses  = 0;
        repeat (6) begin
            @(posedge hclk); #1;
            if (pready_a[1]) pulses++;
        end
        chk("abort pready pulses", pulses, 0);
        run_vec(mk("abort r08", 1, 1'b0, 32'h08, 32'h0, 32'h1234_5678, 1'b0, 3));

        // Reset while pready is high clears outputs without waiting for a clock edge.
        psel_v[0] = 1'b1;
        penable   = 1'b0;
        pwrite    = 1'b0;
        paddr     = 32'h3C;
        @(posedge hclk); #1;
        penable = 1'b1;
        chk("ready before reset pready", {31'd0, pready_a[0]}, 32'd1);
        chk("ready before reset prdata", prdata_a[0], 32'h22);
        #2 hreset = 1'b1;
        #1;
        chk("async reset pready", {31'd0, pready_a[0]}, 32'd0);
        chk("async reset prdata", prdata_a[0], 32'd0);
        psel_v  = '0;
        penable = 1'b0;
        @(posedge hclk);
        #2 hreset = 1'b0;
        @(posedge hclk); #1;

        // Reset during WAIT of a write: the write is lost.
        psel_v[2] = 1'b1;
        penable   = 1'b0;
        pwrite    = 1'b1;
        paddr     = 32'h10;
        pwdata    = 32'hFF;
        @(posedge hclk); #1;
        penable = 1'b1;
        repeat (2) @(posedge hclk);
        #2 hreset = 1'b1;
        #1;
        chk("wait reset pready", {31'd0, pready_a[2]}, 32'd0);
        psel_v  = '0;
        penable = 1'b0;
        @(posedge hclk);
        #2 hreset = 1'b0;
        @(posedge hclk); #1;
        run_vec(mk("post-reset r10 ws5", 2, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 5));
        run_vec(mk("post-reset r14 ws5", 2, 1'b0, 32'h14, 32'h0, 32'h0, 1'b0, 5));
        run_vec(mk("post-reset r04 ws0", 0, 1'b0, 32'h04, 32'h0, 32'h0, 1'b0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
